uart_command_rx: RTL and testbench



---
 rtl/uart_command_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_command_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_command_rx.sv
// 8N1 UART receiver that decodes ASCII drive commands, with a link-loss watchdog forcing STOP.
// All line sampling uses the synchronised rx_s; strobes are registered and last one cycle.
module uart_command_rx #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] data_rx,
    output logic       byte_valid,
    output logic [2:0] command,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       timeout,
    output logic       rx_busy
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
    localparam int unsigned WdW        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(ClksPerBit / 2 - 1);
    localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              armed_q, armed_d;
    logic [7:0]        data_rx_q, data_rx_d;
    logic [2:0]        command_q, command_d;
    logic              byte_valid_q, byte_valid_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              cmd_err_q, cmd_err_d;
    logic              timeout_q, timeout_d;
    logic [WdW-1:0]    wd_q, wd_d;

    logic              dec_legal;
    logic [2:0]        dec_cmd;

    always_comb begin
        dec_legal = 1'b1;
        dec_cmd   = 3'd0;
        case (shift_q)
            8'h53:   dec_cmd = 3'd0;
            8'h46:   dec_cmd = 3'd1;
            8'h42:   dec_cmd = 3'd2;
            8'h4C:   dec_cmd = 3'd3;
            8'h52:   dec_cmd = 3'd4;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q | rx_s_q;
        data_rx_d    = data_rx_q;
        command_d    = command_q;
        byte_valid_d = 1'b0;
        cmd_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        cmd_err_d    = 1'b0;
        timeout_d    = 1'b0;
        wd_d         = wd_q;

        unique case (state_q)
            StIdle: begin
                if (armed_q && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        data_rx_d    = shift_q;
                        byte_valid_d = 1'b1;
                        cmd_valid_d  = dec_legal;
                        cmd_err_d    = !dec_legal;
                        if (dec_legal) begin
                            command_d = dec_cmd;
                        end
                    end else begin
                        // Disarm so a held-low break reports once, not once per bit window.
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A command landing on the terminal count wins over the timeout.
        if (cmd_valid_d) begin
            wd_d = '0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WdMax) begin
                timeout_d = 1'b1;
                command_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            armed_q      <= 1'b0;
            data_rx_q    <= 8'h00;
            command_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            rx_meta_q    <= uart_in;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            data_rx_q    <= data_rx_d;
            command_q    <= command_d;
            byte_valid_q <= byte_valid_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_err_q  <= frame_err_d;
            cmd_err_q    <= cmd_err_d;
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
        end
    end

    assign data_rx    = data_rx_q;
    assign byte_valid = byte_valid_q;
    assign command    = command_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_err  = frame_err_q;
    assign cmd_err    = cmd_err_q;
    assign timeout    = timeout_q;
    assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_command_rx.sv
// Directed bench for uart_command_rx at 20 clocks per bit and a 1000-clock watchdog.
// Expected frame latency: start-bit drive to byte_valid = 2 + 10 + 9*20 + 1 = 193 clocks.
module tb_uart_command_rx;

    localparam int unsigned Cpb     = 20;
    localparam int unsigned Tmo     = 1000;
    localparam int          Latency = 193;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] data_rx;
    logic       byte_valid, cmd_valid, frame_err, cmd_err, timeout, rx_busy;
    logic [2:0] command;

    uart_command_rx #(
        .CLK_FREQ      (1_000_000),
        .BAUD          (50_000),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_in   (uart_in),
        .data_rx   (data_rx),
        .byte_valid(byte_valid),
        .command   (command),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .cmd_err   (cmd_err),
        .timeout   (timeout),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts high cycles and records the cycle of the latest one.
    int n_bv = 0, n_cv = 0, n_fe = 0, n_ce = 0, n_to = 0;
    int last_bv = -1, last_cv = -1, last_ce = -1, last_to = -1;
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid) begin n_bv <= n_bv + 1; last_bv <= cyc; end
            if (cmd_valid)  begin n_cv <= n_cv + 1; last_cv <= cyc; end
            if (frame_err)  n_fe <= n_fe + 1;
            if (cmd_err)    begin n_ce <= n_ce + 1; last_ce <= cyc; end
            if (timeout)    begin n_to <= n_to + 1; last_to <= cyc; end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns the cycle the start bit was driven.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        uart_in = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            tick(Cpb);
        end
        uart_in = stop;
        tick(Cpb);
        tick(10);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    int t, c1, cb, bv0, cv0, fe0, ce0, to0;

    initial begin
        tick(3);
        @(negedge clk);
        check("reset_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data", 32'(data_rx), 32'h00);
        check("reset_cmd", 32'(command), 32'd0);
        check("reset_strobes", {27'd0, byte_valid, cmd_valid, frame_err, cmd_err, timeout}, 32'd0);
        @(posedge clk); #1;

        // 'F'
        bv0 = n_bv; cv0 = n_cv;
        send_byte(8'h46, 1'b1, t);
        check("f_bv_count", 32'(n_bv - bv0), 32'd1);
        check("f_cv_count", 32'(n_cv - cv0), 32'd1);
        check("f_bv_latency", 32'(last_bv - t), 32'(Latency));
        check("f_cv_coincident", 32'(last_cv - t), 32'(Latency));
        check("f_data", 32'(data_rx), 32'h46);
        check("f_cmd", 32'(command), 32'd1);
        check("f_busy_after", 32'(rx_busy), 32'd0);

        // Short low glitch, well under half a bit
        bv0 = n_bv; cv0 = n_cv; fe0 = n_fe; ce0 = n_ce;
        uart_in = 1'b0;
        tick(4);
        uart_in = 1'b1;
        tick(40);
        check("glitch_strobes", 32'((n_bv - bv0) + (n_cv - cv0) + (n_fe - fe0) + (n_ce - ce0)), 32'd0);
        check("glitch_cmd", 32'(command), 32'd1);
        check("glitch_idle", 32'(rx_busy), 32'd0);

        // 0x4C with low stop bit, then line held low as a break
        bv0 = n_bv; cv0 = n_cv; fe0 = n_fe;
        send_byte(8'h4C, 1'b0, t);
        tick(20 * Cpb);
        check("break_fe_count", 32'(n_fe - fe0), 32'd1);
        check("break_bv_count", 32'(n_bv - bv0), 32'd0);
        check("break_cv_count", 32'(n_cv - cv0), 32'd0);
        check("break_data", 32'(data_rx), 32'h46);
        check("break_cmd", 32'(command), 32'd1);
        uart_in = 1'b1;
        tick(20);
        check("break_fe_after_release", 32'(n_fe - fe0), 32'd1);

        // 'R' then illegal 'X'
        send_byte(8'h52, 1'b1, t);
        check("r_cmd", 32'(command), 32'd4);
        bv0 = n_bv; cv0 = n_cv; ce0 = n_ce;
        send_byte(8'h58, 1'b1, t);
        check("x_bv_count", 32'(n_bv - bv0), 32'd1);
        check("x_ce_count", 32'(n_ce - ce0), 32'd1);
        check("x_cv_count", 32'(n_cv - cv0), 32'd0);
        check("x_ce_latency", 32'(last_ce - t), 32'(Latency));
        check("x_data", 32'(data_rx), 32'h58);
        check("x_cmd_hold", 32'(command), 32'd4);

        // Watchdog after 'B'
        to0 = n_to;
        send_byte(8'h42, 1'b1, t);
        cb = last_cv;
        check("b_cv_latency", 32'(cb - t), 32'(Latency));
        check("b_cmd", 32'(command), 32'd2);
        wait_until(cb + Tmo + 100);
        check("wd_to_count", 32'(n_to - to0), 32'd1);
        check("wd_to_time", 32'(last_to - cb), 32'(Tmo));
        check("wd_cmd_stop", 32'(command), 32'd0);
        wait_until(cb + 2 * Tmo + 200);
        check("wd_no_second", 32'(n_to - to0), 32'd1);

        // Command landing exactly on the terminal count suppresses the timeout
        send_byte(8'h46, 1'b1, t);
        c1 = last_cv;
        to0 = n_to;
        wait_until(c1 + Tmo - Latency);
        send_byte(8'h4C, 1'b1, t);
        check("term_cv_time", 32'(last_cv - c1), 32'(Tmo));
        wait_until(c1 + Tmo + 50);
        check("term_no_timeout", 32'(n_to - to0), 32'd0);
        check("term_cmd", 32'(command), 32'd3);

        // Reset in the middle of a frame
        bv0 = n_bv;
        uart_in = 1'b0;
        tick(Cpb);
        uart_in = 1'b1;
        tick(2 * Cpb);
        check("mid_busy", 32'(rx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_data", 32'(data_rx), 32'h00);
        check("mid_rst_cmd", 32'(command), 32'd0);
        check("mid_rst_busy", 32'(rx_busy), 32'd0);
        tick(3);
        reset = 1'b0;
        tick(Cpb * 8);
        check("mid_no_strobe", 32'(n_bv - bv0), 32'd0);
        cv0 = n_cv;
        send_byte(8'h53, 1'b1, t);
        check("s_cv_count", 32'(n_cv - cv0), 32'd1);
        check("s_cv_latency", 32'(last_cv - t), 32'(Latency));
        check("s_data", 32'(data_rx), 32'h53);
        check("s_cmd", 32'(command), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
